// File: rtl/reg_bank_if.sv
// Bus between the multicycle datapath control and the register file:
// one write port and two registered read ports.
interface reg_bank_if #(
  parameter int WIDTH = 32
);
  logic             RegWrite;
  logic [4:0]       WriteReg;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       ReadReg1;
  logic [4:0]       ReadReg2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic             WriteAck;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, WriteAck
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WriteAck
  );
endinterface

// File: rtl/reg_bank.sv
// 32-entry MIPS architectural register file: $0 hardwired to zero, two
// registered read ports with write-to-read bypass, registered write ack.
module reg_bank #(
  parameter int WIDTH    = 32,
  parameter int SP_RESET = 227,
  parameter int RA_RESET = 0
) (
  input  logic       clk,
  input  logic       reset,
  reg_bank_if.slave  bus
);

  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];
  logic [WIDTH-1:0] read_data1_q, read_data1_d;
  logic [WIDTH-1:0] read_data2_q, read_data2_d;
  logic             write_ack_q, write_ack_d;
  logic             write_en;

  // $29 starts at top of stack so the first push needs no setup code.
  function automatic logic [WIDTH-1:0] reset_value(input int idx);
    if (idx == 29)      return WIDTH'(SP_RESET);
    else if (idx == 31) return WIDTH'(RA_RESET);
    else                return '0;
  endfunction

  assign write_en = bus.RegWrite && (bus.WriteReg != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (write_en) regs_d[bus.WriteReg] = bus.WriteData;
    regs_d[0] = '0;
  end

  always_comb begin
    read_data1_d = regs_q[bus.ReadReg1];
    read_data2_d = regs_q[bus.ReadReg2];
    if (write_en && bus.WriteReg == bus.ReadReg1) read_data1_d = bus.WriteData;
    if (write_en && bus.WriteReg == bus.ReadReg2) read_data2_d = bus.WriteData;
    if (bus.ReadReg1 == 5'd0) read_data1_d = '0;
    if (bus.ReadReg2 == 5'd0) read_data2_d = '0;
    // Acked even for $0 so the control FSM sees a uniform handshake.
    write_ack_d = bus.RegWrite;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= reset_value(i);
      read_data1_q <= '0;
      read_data2_q <= '0;
      write_ack_q  <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
      write_ack_q  <= write_ack_d;
    end
  end

  assign bus.ReadData1 = read_data1_q;
  assign bus.ReadData2 = read_data2_q;
  assign bus.WriteAck  = write_ack_q;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: directed vectors push hand-computed
// expected outputs; a monitor pops and compares after every clock edge.
module tb_reg_bank;

  logic clk;
  logic reset;

  reg_bank_if #(.WIDTH(32)) bus ();

  reg_bank #(.WIDTH(32), .SP_RESET(227), .RA_RESET(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        ack;
  } expect_t;

  expect_t exp_q[$];
  int      n_checks = 0;
  int      n_fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and record what the
  // outputs must show after the following rising edge.
  task automatic applyStimulus(input string name, input logic rst,
                               input logic we, input logic [4:0] wreg,
                               input logic [31:0] wdata,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [31:0] e1, input logic [31:0] e2,
                               input logic eack);
    expect_t e;
    @(negedge clk);
    reset         = rst;
    bus.RegWrite  = we;
    bus.WriteReg  = wreg;
    bus.WriteData = wdata;
    bus.ReadReg1  = r1;
    bus.ReadReg2  = r2;
    e.name = name;
    e.d1   = e1;
    e.d2   = e2;
    e.ack  = eack;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    n_checks++;
    if (bus.ReadData1 !== e.d1) begin
      n_fails++;
      $display("[TB] FAIL %s.ReadData1: got 0x%08h expected 0x%08h", e.name, bus.ReadData1, e.d1);
    end
    n_checks++;
    if (bus.ReadData2 !== e.d2) begin
      n_fails++;
      $display("[TB] FAIL %s.ReadData2: got 0x%08h expected 0x%08h", e.name, bus.ReadData2, e.d2);
    end
    n_checks++;
    if (bus.WriteAck !== e.ack) begin
      n_fails++;
      $display("[TB] FAIL %s.WriteAck: got %b expected %b", e.name, bus.WriteAck, e.ack);
    end
  endtask

  // Monitor: every registered output changes only at the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.WriteReg  = 5'd0;
    bus.WriteData = 32'h0;
    bus.ReadReg1  = 5'd0;
    bus.ReadReg2  = 5'd0;

    //             name          rst  we  wreg   wdata         r1     r2     exp1          exp2          ack
    applyStimulus("reset",       1, 0, 5'd0,  32'h0,        5'd29, 5'd31, 32'h0,        32'h0,        0);
    applyStimulus("rst_sp_ra",   0, 0, 5'd0,  32'h0,        5'd29, 5'd31, 32'd227,      32'h0,        0);
    applyStimulus("rst_r0_r5",   0, 0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'h0,        0);
    applyStimulus("wr_r8",       0, 1, 5'd8,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        1);
    applyStimulus("rd_r8",       0, 0, 5'd0,  32'h0,        5'd8,  5'd0,  32'hDEADBEEF, 32'h0,        0);
    applyStimulus("wr_r0",       0, 1, 5'd0,  32'h12345678, 5'd0,  5'd8,  32'h0,        32'hDEADBEEF, 1);
    applyStimulus("rd_r0",       0, 0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        0);
    applyStimulus("preload_r10", 0, 1, 5'd10, 32'h1,        5'd8,  5'd0,  32'hDEADBEEF, 32'h0,        1);
    applyStimulus("bypass_r10",  0, 1, 5'd10, 32'hA5A5A5A5, 5'd10, 5'd10, 32'hA5A5A5A5, 32'hA5A5A5A5, 1);
    applyStimulus("wr_sp",       0, 1, 5'd29, 32'h100,      5'd10, 5'd0,  32'hA5A5A5A5, 32'h0,        1);
    applyStimulus("wr_ra",       0, 1, 5'd31, 32'h40,       5'd29, 5'd31, 32'h100,      32'h40,       1);
    applyStimulus("rd_sp_ra",    0, 0, 5'd0,  32'h0,        5'd29, 5'd31, 32'h100,      32'h40,       0);
    applyStimulus("rst_with_wr", 1, 1, 5'd29, 32'h55,       5'd29, 5'd10, 32'h0,        32'h0,        0);
    applyStimulus("post_rst_sp", 0, 0, 5'd0,  32'h0,        5'd29, 5'd10, 32'd227,      32'h0,        0);
    applyStimulus("post_rst_r8", 0, 0, 5'd0,  32'h0,        5'd8,  5'd31, 32'h0,        32'h0,        0);
    applyStimulus("bypass_p1",   0, 1, 5'd7,  32'h77,       5'd7,  5'd8,  32'h77,       32'h0,        1);
    applyStimulus("bypass_p2",   0, 1, 5'd8,  32'hCAFEF00D, 5'd7,  5'd8,  32'h77,       32'hCAFEF00D, 1);
    applyStimulus("rd_swap",     0, 0, 5'd0,  32'h0,        5'd8,  5'd7,  32'hCAFEF00D, 32'h77,       0);

    @(negedge clk);
    bus.RegWrite = 1'b0;
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Architectural register file of the multicycle MIPS datapath, the consumer of the write-destination index chosen by the write-register multiplexer (rd from immediate[15:11], rt, $31 or $29). It stores 32 general-purpose registers. Writes are accepted on the write port from the write-back stage. Two synchronous read ports feed the A/B operand registers. Reads are registered and include write-to-read bypass, and $29 (stack pointer) resets to a non-zero top-of-stack value.

## Interface
- WIDTH, 32, data width of every register and port
- SP_RESET, 227, reset value of register $29
- RA_RESET, 0, reset value of register $31
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- RegWrite  in  1  write enable for the current cycle
- WriteReg  in  5  destination register index (write-register mux output)
- WriteData  in  WIDTH  data to write
- ReadReg1  in  5  read port 1 index (rs)
- ReadReg2  in  5  read port 2 index (rt)
- ReadData1  out  WIDTH  registered contents of ReadReg1
- ReadData2  out  WIDTH  registered contents of ReadReg2
- WriteAck  out  1  one-cycle pulse: previous cycle's write was committed

## Operation
- Storage: 32 x WIDTH registers, indices 0..31.
- Register $0 is hardwired to zero.
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0, including under bypass.
- Reset (reset=1 at a rising edge):
  - All registers are cleared to 0, except $29=SP_RESET and $31=RA_RESET.
  - ReadData1, ReadData2 and WriteAck are cleared to 0.
  - Reset wins over a simultaneous RegWrite; that write is lost and no ack is produced.
- Write: when RegWrite=1 at a rising edge and reset=0, register[WriteReg] takes WriteData.
  - This applies to every index except 0.
  - There is no partial or byte write; the full WIDTH is written.
- Read: at every rising edge with reset=0, ReadDataN takes the value of register[ReadRegN].
- Bypass: if RegWrite=1, WriteReg==ReadRegN and WriteReg!=0 in the same cycle, ReadDataN takes WriteData (the new value), not the old contents.
  - Both ports bypass independently.
  - Both ports may read the same index.
- WriteAck: registered copy of (RegWrite & ~reset). It is asserted even for writes to $0, so the control FSM has a uniform completion handshake.
- No state machine beyond storage. Outputs hold their values when addresses do not change and no write hits them.

## Timing
- Read latency: 1 cycle. Addresses presented before edge k appear on ReadData after edge k.
- Write latency: 1 cycle.
  - Data is visible to a non-bypassed read one edge after the write.
  - It is visible to a same-edge read through the bypass.
- WriteAck is high for exactly the cycle after an accepted write. Back-to-back writes keep it high continuously.
- Simultaneous read on both ports and a write, all to the same index: both ports return WriteData.
- Index arithmetic is 5-bit; there is no out-of-range case.

## Test plan
- Reset values: apply reset=1 for 1 cycle, then read $29/$31 and $0/$5.
  - Expect ReadData1=227, ReadData2=0 for $29/$31.
  - Expect 0/0 for $0/$5.
  - WriteAck=0.
- Write then read: write $8=0xDEADBEEF, then read ReadReg1=8 next cycle.
  - Expect 0xDEADBEEF one edge later.
  - Expect WriteAck=1 for exactly one cycle.
- $0 protection:
  - Write $0=0x12345678 with ReadReg1=0 in the same cycle and the next cycle. Expect ReadData1=0 both times and WriteAck=1.
- Bypass:
  - Preload $10=1.
  - Write $10=0xA5A5A5A5 while ReadReg1=ReadReg2=10 in the same cycle. Both ports must show 0xA5A5A5A5 after that edge, not 1.
- Stack-pointer write-back path: write $29=0x100 (WriteReg=29), then $31=0x40.
  - Read ReadReg1=29 and ReadReg2=31. Expect 0x100 and 0x40.
  - Back-to-back writes hold WriteAck high for 2 cycles.
- Reset mid-operation:
  - Assert reset in the same cycle as RegWrite to $29=0x55. Expect $29=227 afterwards and WriteAck=0.
  - All previously written registers ($8, $10) read 0.
